// File: rtl/be_row_assembler.sv
`default_nettype none
// ============================================================================
// Module   : be_row_assembler
// Purpose  : Packs in-order DRAM read beats into full scratchpad rows. It
//            masks the columns beyond the requested width and emits one row at
//            a time with a valid/ready handshake.
// Options  : BE_ASM_ID_CHECK_EN - checks each beat_id against the running
//            beat count and raises a sticky id_err when they differ.
// Revision : 1.0 - initial release
// ============================================================================
module be_row_assembler #(
    parameter int NUM_COLS  = 32,
    parameter int ELEM_BITS = 16,
    parameter int BUS_BITS  = 64,
    parameter int ADDR_W    = 17,
    parameter int ID_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [ADDR_W-1:0]             start_spad_addr,
    input  logic [$clog2(NUM_COLS)-1:0]   start_num_rows,
    input  logic [$clog2(NUM_COLS)-1:0]   start_num_cols,

    input  logic                          beat_valid,
    output logic                          beat_ready,
    input  logic [ID_W-1:0]               beat_id,
    input  logic [BUS_BITS-1:0]           beat_rdata,

    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [ADDR_W-1:0]             row_spad_addr,
    output logic [NUM_COLS*ELEM_BITS-1:0] row_wdata,
    output logic [NUM_COLS-1:0]           row_valid_mask,

    output logic                          busy,
    output logic                          done,
    output logic                          id_err
);

    localparam int c_CW      = $clog2(NUM_COLS);
    localparam int c_EPB     = BUS_BITS / ELEM_BITS;
    localparam int c_EPB_LOG = $clog2(c_EPB);
    localparam logic [c_CW-1:0]   c_ONE       = c_CW'(1);
    localparam logic [ADDR_W-1:0] c_ROW_BYTES = ADDR_W'(NUM_COLS * ELEM_BITS / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                          r_state;
    logic [ADDR_W-1:0]               r_row_addr;
    logic [c_CW-1:0]                 r_num_rows;
    logic [c_CW-1:0]                 r_num_cols;
    logic [c_CW-1:0]                 r_last_beat;
    logic [c_CW-1:0]                 r_beat_cnt;
    logic [c_CW-1:0]                 r_row_idx;
    logic [NUM_COLS*ELEM_BITS-1:0]   r_row_buf;
    logic [NUM_COLS-1:0]             r_mask;
    logic                            r_row_valid;
    logic                            r_done;

    logic [NUM_COLS*ELEM_BITS-1:0]   w_fill_buf;
    logic [NUM_COLS-1:0]             w_start_mask;

    // Merge the current beat into the row; lanes past num_cols stay zero.
    always_comb begin
        w_fill_buf = r_row_buf;
        for (int c = 0; c < NUM_COLS; c++) begin
            if ((r_beat_cnt == c_CW'(c / c_EPB)) && (c_CW'(c) <= r_num_cols)) begin
                w_fill_buf[c*ELEM_BITS +: ELEM_BITS] = beat_rdata[(c % c_EPB)*ELEM_BITS +: ELEM_BITS];
            end
        end
    end

    always_comb begin
        w_start_mask = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            w_start_mask[c] = (c_CW'(c) <= start_num_cols);
        end
    end

`ifdef BE_ASM_ID_CHECK_EN
    logic [ID_W-1:0] r_id_cnt;
    logic            r_id_err;
    localparam logic [ID_W-1:0] c_ID_ONE = ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_cnt <= '0;
            r_id_err <= 1'b0;
        end else if (r_state == S_IDLE && start_valid) begin
            r_id_cnt <= '0;
            r_id_err <= 1'b0;
        end else if (r_state == S_FILL && beat_valid) begin
            r_id_cnt <= r_id_cnt + c_ID_ONE;
            if (beat_id != r_id_cnt) begin
                r_id_err <= 1'b1;
            end
        end
    end

    assign id_err = r_id_err;
`else
    logic w_unused_beat_id;
    assign w_unused_beat_id = ^beat_id;
    assign id_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row_addr  <= '0;
            r_num_rows  <= '0;
            r_num_cols  <= '0;
            r_last_beat <= '0;
            r_beat_cnt  <= '0;
            r_row_idx   <= '0;
            r_row_buf   <= '0;
            r_mask      <= '0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_row_addr  <= start_spad_addr;
                        r_num_rows  <= start_num_rows;
                        r_num_cols  <= start_num_cols;
                        // Last beat index is floor(num_cols / EPB); EPB is a power of two.
                        r_last_beat <= start_num_cols >> c_EPB_LOG;
                        r_beat_cnt  <= '0;
                        r_row_idx   <= '0;
                        r_row_buf   <= '0;
                        r_mask      <= w_start_mask;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_valid) begin
                        r_row_buf <= w_fill_buf;
                        if (r_beat_cnt == r_last_beat) begin
                            r_beat_cnt  <= '0;
                            r_row_valid <= 1'b1;
                            r_state     <= S_EMIT;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_ONE;
                        end
                    end
                end
                S_EMIT: begin
                    if (row_ready) begin
                        r_row_valid <= 1'b0;
                        if (r_row_idx == r_num_rows) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_row_idx  <= r_row_idx + c_ONE;
                            r_row_addr <= r_row_addr + c_ROW_BYTES;
                            r_row_buf  <= '0;
                            r_state    <= S_FILL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready    = (r_state == S_IDLE);
    assign beat_ready     = (r_state == S_FILL);
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign row_valid      = r_row_valid;
    assign row_spad_addr  = r_row_addr;
    assign row_wdata      = r_row_buf;
    assign row_valid_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_be_row_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_be_row_assembler
// Purpose  : Directed self-checking bench for be_row_assembler (32x16b rows,
//            64b beats); honours BE_ASM_ID_CHECK_EN for id_err expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_be_row_assembler;

    localparam int NUM_COLS  = 32;
    localparam int ELEM_BITS = 16;
    localparam int BUS_BITS  = 64;
    localparam int ADDR_W    = 17;
    localparam int ID_W      = 4;

`ifdef BE_ASM_ID_CHECK_EN
    localparam logic c_ID_ERR_EXP = 1'b1;
`else
    localparam logic c_ID_ERR_EXP = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start_valid;
    logic                          start_ready;
    logic [ADDR_W-1:0]             start_spad_addr;
    logic [4:0]                    start_num_rows;
    logic [4:0]                    start_num_cols;
    logic                          beat_valid;
    logic                          beat_ready;
    logic [ID_W-1:0]               beat_id;
    logic [BUS_BITS-1:0]           beat_rdata;
    logic                          row_valid;
    logic                          row_ready;
    logic [ADDR_W-1:0]             row_spad_addr;
    logic [NUM_COLS*ELEM_BITS-1:0] row_wdata;
    logic [NUM_COLS-1:0]           row_valid_mask;
    logic                          busy;
    logic                          done;
    logic                          id_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    be_row_assembler #(
        .NUM_COLS (NUM_COLS),
        .ELEM_BITS(ELEM_BITS),
        .BUS_BITS (BUS_BITS),
        .ADDR_W   (ADDR_W),
        .ID_W     (ID_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .start_spad_addr(start_spad_addr),
        .start_num_rows (start_num_rows),
        .start_num_cols (start_num_cols),
        .beat_valid     (beat_valid),
        .beat_ready     (beat_ready),
        .beat_id        (beat_id),
        .beat_rdata     (beat_rdata),
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .row_spad_addr  (row_spad_addr),
        .row_wdata      (row_wdata),
        .row_valid_mask (row_valid_mask),
        .busy           (busy),
        .done           (done),
        .id_err         (id_err)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [4:0] rows, input logic [4:0] cols);
        start_valid     = 1'b1;
        start_spad_addr = base;
        start_num_rows  = rows;
        start_num_cols  = cols;
        step();
        start_valid = 1'b0;
        check("start_busy", busy, 1'b1);
    endtask

    task automatic send_beat(input int first_elem, input int id);
        beat_valid = 1'b1;
        beat_id    = ID_W'(id);
        for (int j = 0; j < 4; j++) begin
            beat_rdata[j*16 +: 16] = 16'(first_elem + j);
        end
        step();
        beat_valid = 1'b0;
    endtask

    task automatic fill_row(input int base_val, input int nbeats, input int id0);
        for (int k = 0; k < nbeats; k++) begin
            send_beat(base_val + 4*k, id0 + k);
            if (k < nbeats - 1) check("row_valid_early", row_valid, 1'b0);
        end
    endtask

    task automatic check_row(input string tag, input int base_val, input int ncols, input logic [ADDR_W-1:0] addr);
        logic [511:0] exp_data;
        logic [31:0]  exp_mask;
        exp_data = '0;
        exp_mask = '0;
        for (int c = 0; c <= ncols; c++) begin
            exp_data[c*16 +: 16] = 16'(base_val + c);
            exp_mask[c]          = 1'b1;
        end
        check({tag, "_row_valid"}, row_valid, 1'b1);
        check({tag, "_beat_ready"}, beat_ready, 1'b0);
        check({tag, "_mask"}, row_valid_mask, exp_mask);
        check({tag, "_addr"}, row_spad_addr, addr);
        check({tag, "_wdata"}, row_wdata, exp_data);
    endtask

    task automatic accept_row();
        row_ready = 1'b1;
        step();
        row_ready = 1'b0;
    endtask

    task automatic full_row_test(input string tag);
        start_xfer(17'h100, 5'd0, 5'd31);
        fill_row(0, 8, 0);
        check_row(tag, 0, 31, 17'h100);
        accept_row();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_valid_end"}, row_valid, 1'b0);
        check({tag, "_start_ready"}, start_ready, 1'b1);
        check({tag, "_id_err"}, id_err, 1'b0);
        step();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        start_valid     = 1'b0;
        start_spad_addr = '0;
        start_num_rows  = '0;
        start_num_cols  = '0;
        beat_valid      = 1'b0;
        beat_id         = '0;
        beat_rdata      = '0;
        row_ready       = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_beat_ready", beat_ready, 1'b0);
        check("rst_row_valid", row_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_id_err", id_err, 1'b0);
        check("rst_addr", row_spad_addr, 17'h0);
        check("rst_wdata", row_wdata, 512'h0);
        check("rst_mask", row_valid_mask, 32'h0);

        // Full row, elements equal to their column index.
        full_row_test("full");

        // Partial row: beat 1 lanes 6 and 7 must be dropped.
        start_xfer(17'h200, 5'd0, 5'd5);
        fill_row(16'h1000, 2, 0);
        check_row("part", 16'h1000, 5, 17'h200);
        accept_row();
        check("part_done", done, 1'b1);
        step();

        // Three rows with backpressure; stray beats and starts must be ignored.
        start_xfer(17'h100, 5'd2, 5'd31);
        for (int r = 0; r < 3; r++) begin
            fill_row(r*256, 8, r*8);
            for (int h = 0; h < 5; h++) begin
                beat_valid  = 1'b1;
                beat_rdata  = '1;
                start_valid = 1'b1;
                step();
                check_row("bp", r*256, 31, ADDR_W'(17'h100 + r*64));
                check("bp_busy", busy, 1'b1);
            end
            beat_valid  = 1'b0;
            start_valid = 1'b0;
            accept_row();
            check("bp_done", done, (r == 2));
        end
        check("bp_id_err", id_err, 1'b0);
        step();
        check("bp_done_pulse", done, 1'b0);

        // Reset in the middle of a row.
        start_xfer(17'h100, 5'd0, 5'd31);
        send_beat(0, 0);
        send_beat(4, 1);
        send_beat(8, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_row_valid", row_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_start_ready", start_ready, 1'b1);
        check("mid_rst_beat_ready", beat_ready, 1'b0);
        check("mid_rst_wdata", row_wdata, 512'h0);
        check("mid_rst_mask", row_valid_mask, 32'h0);
        full_row_test("after_rst");

        // Beat id sequence 0,1,5,3: third beat is out of order.
        start_xfer(17'h300, 5'd0, 5'd15);
        send_beat(0, 0);
        send_beat(4, 1);
        check("id_before", id_err, 1'b0);
        send_beat(8, 5);
        check("id_third", id_err, c_ID_ERR_EXP);
        send_beat(12, 3);
        check("id_fourth", id_err, c_ID_ERR_EXP);
        check_row("id", 0, 15, 17'h300);
        accept_row();
        check("id_done", done, 1'b1);
        check("id_at_done", id_err, c_ID_ERR_EXP);
        step();
        start_xfer(17'h300, 5'd0, 5'd15);
        check("id_cleared", id_err, 1'b0);
        fill_row(0, 4, 0);
        check_row("id2", 0, 15, 17'h300);
        accept_row();
        check("id2_err", id_err, 1'b0);
        check("id2_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
